cluster_unpacker1536: RTL
=========================

// Module: cluster_unpacker1536
// PURPOSE
//  Receive-side inverse of the 1536-pad priority encoder/cluster packer. Takes a stream of encoded clusters
//  {adr[10:0], cnt[2:0]}, one per clock, and expands each back into a 1536-bit pad hit map.
//  Clusters are accumulated per frame, and the completed map is presented once per frame.
//  Used on the back-end and in loopback benches to check packer output against the original vpfs.
// PARAMETERS
//  MXPADS      1536  number of pads in the map
//  MXADRBITS   11    cluster address width
//  MXCNTBITS   3     cluster count width; cluster size = cnt+1 pads
//  INVALID_ADR 11'h7FE  encoder "no cluster" address; always dropped silently
// PORTS
//  clock          in   1        single clock domain
//  reset_n        in   1        synchronous reset, active-low
//  clst_valid     in   1        adr/cnt valid this cycle
//  clst_adr       in   11       first pad of the cluster
//  clst_cnt       in   3        extra pads after clst_adr (size-1)
//  frame_end      in   1        last cycle of the current frame; clusters in this cycle still belong to it
//  vpfs_out       out  MXPADS   registered pad map of the last completed frame
//  frame_valid    out  1        1-cycle pulse when vpfs_out updates
//  nclusters      out  8        accepted clusters in the last completed frame, saturates at 255
//  err_bad_adr    out  1        sticky: a valid cluster had adr >= MXPADS and != INVALID_ADR
//  err_clip       out  1        sticky: a cluster span ran past pad MXPADS-1
//  synced         out  1        1 once the first frame_end has been seen
// BEHAVIOUR
//  Reset (reset_n=0 on a clock edge) sets state=SYNC and clears the working map, vpfs_out, nclusters,
//   frame_valid, err_bad_adr, err_clip and synced to 0. Reset mid-frame discards the partial frame.
//  FSM states:
//   SYNC: clusters are ignored. On frame_end -> ACCUM, synced<=1, with no frame_valid pulse.
//   ACCUM: accept clusters. On frame_end -> ACCUM; the frame is emitted.
//  Expansion: mask = ((1<<(cnt+1))-1) << adr, truncated to MXPADS bits.
//   In ACCUM with clst_valid=1 and adr < MXPADS, the working map is OR'ed with the mask.
//   Overlapping clusters OR together; a duplicate cluster is harmless to the map.
//   If adr+cnt > MXPADS-1, the pads beyond 1535 are dropped and err_clip is set.
//   If adr == INVALID_ADR, the cluster is dropped with no error and no count.
//   Any other adr >= MXPADS: the cluster is dropped and err_bad_adr is set.
//  Counting: every accepted cluster increments the per-frame count by 1, saturating at 255.
//  Frame emit, when frame_end=1 in ACCUM at cycle M:
//   vpfs_out <= working map | mask of any cluster in cycle M.
//   nclusters <= count including cycle M. frame_valid <= 1 at M+1.
//   The working map and count restart at 0 at M+1. A cluster arriving in cycle M+1 belongs to the new frame.
//  Back-to-back frame_end, each cycle: each emits a frame, which may be empty (all zeros, nclusters=0).
//  Latency: a cluster in cycle N followed by frame_end in cycle M>=N appears on vpfs_out at M+1.
//  Outputs hold between frame_valid pulses.
//  Error flags are sticky until reset.
// STRUCTURE
//  Shared package gem_pkg: MXPADS, MXADRBITS, MXCNTBITS, INVALID_ADR.
//   The same constants are used by the packer, so both ends agree.
//  Sub-module cluster_mask1536: combinational {adr,cnt} -> MXPADS-bit mask plus clip flag.
//   Implement it as a per-pad compare (pad>=adr && pad<=adr+cnt) rather than a wide shifter.
//  The top level holds the FSM, working map, output register, counter and error flags.
// TESTING
//  1 Reset, then frame_end -> synced=1, no frame_valid.
//    Then a cluster adr=10 cnt=2, then frame_end -> at M+1 vpfs_out[12:10]=3'b111, all other bits 0,
//    nclusters=1, frame_valid for 1 cycle.
//  2 Clusters adr=0 cnt=7 and adr=4 cnt=1 (overlapping), with frame_end on the 2nd cluster ->
//    vpfs_out[7:0]=8'hFF, nclusters=2.
//  3 adr=1534 cnt=3 -> vpfs_out[1535:1534]=2'b11, err_clip=1.
//    adr=1600 -> map unchanged, err_bad_adr=1.
//    adr=11'h7FE -> no error, nclusters unchanged.
//  4 frame_end on 3 consecutive cycles with no clusters -> 3 frame_valid pulses, vpfs_out=0, nclusters=0.
//  5 300 valid clusters in one frame -> nclusters=255.
//    Assert reset_n=0 mid-frame -> all outputs 0, state SYNC, and the next frame_end gives no pulse.
//  6 Loopback: random vpfs -> packer -> this block.
//    The union of the decoded frames equals the original clustered map, with a scoreboard compare per frame.

Source files
------------

// File: rtl/gem_pkg.sv
// -----------------------------------------------------------------------------
// gem_pkg
// Constants shared by the 1536-pad cluster packer and the cluster unpacker,
// so that both ends of the link agree on the map size and the cluster
// encoding {adr[10:0], cnt[2:0]}.
//   MXPADS      : number of pads in a hit map
//   MXADRBITS   : cluster address width
//   MXCNTBITS   : cluster count width (cluster size = cnt+1 pads)
//   INVALID_ADR : encoder "no cluster" address, dropped silently by the receiver
// Also holds the unpacker FSM state type and a saturating counter helper.
// -----------------------------------------------------------------------------
package gem_pkg;

  localparam int MXPADS    = 1536;
  localparam int MXADRBITS = 11;
  localparam int MXCNTBITS = 3;
  localparam int NCLBITS   = 8;

  localparam logic [MXADRBITS-1:0] INVALID_ADR = 11'h7FE;

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_ACCUM = 1'b1
  } unp_state_e;

  // Increment by inc, holding at all-ones instead of wrapping.
  function automatic logic [NCLBITS-1:0] sat_inc(input logic [NCLBITS-1:0] v,
                                                 input logic               inc);
    logic [NCLBITS-1:0] r;
    r = v;
    if (inc && (v != {NCLBITS{1'b1}})) begin
      r = v + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cluster_mask1536.sv
// -----------------------------------------------------------------------------
// cluster_mask1536
// Combinational expansion of one encoded cluster into a pad mask.
// Pad p is set when adr <= p <= adr+cnt. Each pad has its own small
// comparator pair instead of a 1536-bit barrel shifter; pads past the end of
// the map simply have no comparator, which gives the truncation for free.
// Ports:
//   i_adr  [10:0]   first pad of the cluster
//   i_cnt  [2:0]    extra pads after i_adr
//   o_mask [1535:0] expanded pad mask (all zero when i_adr >= MXPADS)
//   o_clip          cluster starts inside the map but runs past pad MXPADS-1
// -----------------------------------------------------------------------------
module cluster_mask1536
  import gem_pkg::*;
(
  input  logic [MXADRBITS-1:0] i_adr,
  input  logic [MXCNTBITS-1:0] i_cnt,
  output logic [MXPADS-1:0]    o_mask,
  output logic                 o_clip
);

  // One extra bit so adr+cnt cannot wrap (max 2047+7).
  logic [MXADRBITS:0] w_first;
  logic [MXADRBITS:0] w_last;

  assign w_first = {1'b0, i_adr};
  assign w_last  = w_first + {{(MXADRBITS+1-MXCNTBITS){1'b0}}, i_cnt};

  for (genvar p = 0; p < MXPADS; p++) begin : g_pad
    localparam logic [MXADRBITS:0] PAD = (MXADRBITS+1)'(p);
    assign o_mask[p] = (w_first <= PAD) && (PAD <= w_last);
  end

  assign o_clip = (w_first < (MXADRBITS+1)'(MXPADS)) &&
                  (w_last  > (MXADRBITS+1)'(MXPADS-1));

endmodule

// File: rtl/cluster_unpacker1536.sv
// -----------------------------------------------------------------------------
// cluster_unpacker1536
// Receive-side inverse of the 1536-pad cluster packer. Expands one cluster
// {adr,cnt} per clock into a working pad map, and on frame_end publishes the
// completed map together with the number of accepted clusters.
// Ports:
//   clock        single clock domain
//   reset_n      synchronous reset, active-low
//   clst_valid   adr/cnt valid this cycle
//   clst_adr     first pad of the cluster
//   clst_cnt     extra pads after clst_adr (size-1)
//   frame_end    last cycle of the frame; clusters in this cycle belong to it
//   vpfs_out     registered pad map of the last completed frame
//   frame_valid  1-cycle pulse when vpfs_out updates
//   nclusters    accepted clusters in the last completed frame (sat. 255)
//   err_bad_adr  sticky: cluster with adr >= MXPADS and != INVALID_ADR
//   err_clip     sticky: cluster span ran past pad MXPADS-1
//   synced       set once the first frame_end has been seen
// -----------------------------------------------------------------------------
module cluster_unpacker1536
  import gem_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clst_valid,
  input  logic [MXADRBITS-1:0] clst_adr,
  input  logic [MXCNTBITS-1:0] clst_cnt,
  input  logic                 frame_end,
  output logic [MXPADS-1:0]    vpfs_out,
  output logic                 frame_valid,
  output logic [NCLBITS-1:0]   nclusters,
  output logic                 err_bad_adr,
  output logic                 err_clip,
  output logic                 synced
);

  unp_state_e r_state;
  unp_state_e w_state_nxt;

  logic [MXPADS-1:0]  r_map;
  logic [NCLBITS-1:0] r_cnt;

  logic [MXPADS-1:0]  w_mask;
  logic               w_clip;
  logic               w_in_range;
  logic               w_accept;
  logic               w_bad;
  logic               w_emit;
  logic               w_sync_hit;
  logic [MXPADS-1:0]  w_map_upd;
  logic [NCLBITS-1:0] w_cnt_upd;

  cluster_mask1536 u_mask (
    .i_adr  (clst_adr),
    .i_cnt  (clst_cnt),
    .o_mask (w_mask),
    .o_clip (w_clip)
  );

  assign w_in_range = (clst_adr < MXADRBITS'(MXPADS));

  // Next-state and per-cycle control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_bad       = 1'b0;
    w_emit      = 1'b0;
    w_sync_hit  = 1'b0;
    unique case (r_state)
      ST_SYNC: begin
        // Clusters before the first frame boundary belong to an unknown
        // frame and are discarded without flagging anything.
        if (frame_end) begin
          w_state_nxt = ST_ACCUM;
          w_sync_hit  = 1'b1;
        end
      end
      ST_ACCUM: begin
        w_accept = clst_valid && w_in_range;
        w_bad    = clst_valid && !w_in_range && (clst_adr != INVALID_ADR);
        w_emit   = frame_end;
      end
      default: w_state_nxt = ST_SYNC;
    endcase
  end

  // Working map/count including this cycle's cluster, so a cluster that
  // arrives together with frame_end lands in the emitted frame.
  assign w_map_upd = w_accept ? (r_map | w_mask) : r_map;
  assign w_cnt_upd = sat_inc(r_cnt, w_accept);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= ST_SYNC;
      r_map       <= '0;
      r_cnt       <= '0;
      vpfs_out    <= '0;
      nclusters   <= '0;
      frame_valid <= 1'b0;
      err_bad_adr <= 1'b0;
      err_clip    <= 1'b0;
      synced      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      frame_valid <= w_emit;
      if (w_sync_hit) begin
        synced <= 1'b1;
      end
      if (w_bad) begin
        err_bad_adr <= 1'b1;
      end
      if (w_accept && w_clip) begin
        err_clip <= 1'b1;
      end
      if (w_emit) begin
        vpfs_out  <= w_map_upd;
        nclusters <= w_cnt_upd;
        r_map     <= '0;
        r_cnt     <= '0;
      end else begin
        r_map <= w_map_upd;
        r_cnt <= w_cnt_upd;
      end
    end
  end

endmodule
